// File: rtl/systolic_array_pkg.sv
// -----------------------------------------------------------------------------
// systolic_array_pkg
// Shared types and helpers for the weight-stationary systolic array.
//   data_type : signed 32-bit two's complement datapath word
//   mac()     : wrapping multiply-accumulate used by every PE
// -----------------------------------------------------------------------------
package systolic_array_pkg;

  typedef logic signed [31:0] data_type;

  localparam int unsigned DATA_W = 32;

  // Product and sum are both evaluated in a 32-bit context, so overflow wraps
  // instead of growing or saturating.
  function automatic data_type mac(input data_type acc,
                                   input data_type act,
                                   input data_type wgt);
    data_type prod;
    prod = act * wgt;
    return acc + prod;
  endfunction

endpackage

// File: rtl/systolic_array_if.sv
// -----------------------------------------------------------------------------
// systolic_array_if
// Bundles the array's data-side signals for the bench or an enclosing
// datapath.
//   weight_update : shift the weight column into the array this cycle
//   activation    : skewed activation row, element k feeds PE column k
//   weight        : weight column, element z feeds PE row z
//   result        : registered result column, element z is output row z
//
// Flow control: there is no valid/ready pair. Every signal is sampled or
// produced on every rising edge, and the caller owns all timing, i.e. it knows
// which cycle each result appears in from the fixed array latency.
// -----------------------------------------------------------------------------
interface systolic_array_if #(
  parameter int ACTIVATION_COUNT = 16,
  parameter int WEIGHT_COUNT     = 16
) ();
  import systolic_array_pkg::*;

  logic     weight_update;
  data_type activation [0:ACTIVATION_COUNT-1];
  data_type weight     [0:WEIGHT_COUNT-1];
  data_type result     [0:WEIGHT_COUNT-1];

  // Buffer side: drives weights/activations, consumes results.
  modport master (
    output weight_update,
    output activation,
    output weight,
    input  result
  );

  // Array side.
  modport slave (
    input  weight_update,
    input  activation,
    input  weight,
    output result
  );

endinterface

// File: rtl/systolic_pe.sv
// -----------------------------------------------------------------------------
// systolic_pe
// One multiply-accumulate cell of the weight-stationary array.
//   clk_i, rst_i      : clock, asynchronous active-low reset
//   weight_update_i   : load weight_in into the weight register
//   weight_in         : weight from the left neighbour (or the array input)
//   act_in            : activation from the PE above (or the array input)
//   sum_in            : partial sum from the left neighbour (0 in column 0)
//   weight_out        : registered weight, feeds the right neighbour's chain
//   act_out           : registered activation, feeds the PE below
//   sum_out           : registered partial sum, feeds the right neighbour
// -----------------------------------------------------------------------------
module systolic_pe
  import systolic_array_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     weight_update_i,
  input  data_type weight_in,
  input  data_type act_in,
  input  data_type sum_in,
  output data_type weight_out,
  output data_type act_out,
  output data_type sum_out
);

  data_type weight_d, weight_q;
  data_type act_d,    act_q;
  data_type sum_d,    sum_q;

  // The MAC uses the incoming activation combinationally and the weight as
  // held before this edge, so a weight shift in the same cycle does not
  // affect the product computed on that edge.
  always_comb begin
    weight_d = weight_update_i ? weight_in : weight_q;
    act_d    = act_in;
    sum_d    = mac(sum_in, act_in, weight_q);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      weight_q <= '0;
      act_q    <= '0;
      sum_q    <= '0;
    end else begin
      weight_q <= weight_d;
      act_q    <= act_d;
      sum_q    <= sum_d;
    end
  end

  assign weight_out = weight_q;
  assign act_out    = act_q;
  assign sum_out    = sum_q;

endmodule

// File: rtl/systolic_array.sv
// -----------------------------------------------------------------------------
// systolic_array
// Weight-stationary WEIGHT_COUNT x ACTIVATION_COUNT matrix multiplier, C = W x X.
//   clk_i           : clock, all state updates on the rising edge
//   rst_i           : asynchronous active-low reset, clears all state
//   weight_update_i : shift weight_i into column 0, older columns move right
//   activation_i    : skewed activations, element k feeds PE column k
//   weight_i        : weight column, element z feeds PE row z
//   result_o        : registered results, element z is output row z
// Activations move down rows, partial sums move right across columns, and a
// final register row captures the rightmost column's sums.
// C[z][j] is on result_o[z] during cycle j+z+ACTIVATION_COUNT+1 when X[k][j]
// is driven on activation_i[k] in cycle j+k.
// -----------------------------------------------------------------------------
module systolic_array
  import systolic_array_pkg::*;
#(
  parameter int ACTIVATION_COUNT = 16,
  parameter int WEIGHT_COUNT     = 16
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     weight_update_i,
  input  data_type activation_i [0:ACTIVATION_COUNT-1],
  input  data_type weight_i     [0:WEIGHT_COUNT-1],
  output data_type result_o     [0:WEIGHT_COUNT-1]
);

  // Inter-PE links. The last row's activations and the last column's weights
  // leave the array, so those links are sized one short.
  data_type act_grid    [0:WEIGHT_COUNT-2][0:ACTIVATION_COUNT-1];
  data_type weight_grid [0:WEIGHT_COUNT-1][0:ACTIVATION_COUNT-2];
  data_type sum_grid    [0:WEIGHT_COUNT-1][0:ACTIVATION_COUNT-1];

  for (genvar z = 0; z < WEIGHT_COUNT; z++) begin : g_row
    for (genvar k = 0; k < ACTIVATION_COUNT; k++) begin : g_col
      data_type act_in;
      data_type weight_in;
      data_type sum_in;
      data_type act_out;
      data_type weight_out;

      if (z == 0) begin : g_act_top
        assign act_in = activation_i[k];
      end else begin : g_act_mid
        assign act_in = act_grid[z-1][k];
      end

      if (z < WEIGHT_COUNT - 1) begin : g_act_down
        assign act_grid[z][k] = act_out;
      end else begin : g_act_last
        data_type act_unused;
        assign act_unused = act_out;
      end

      if (k == 0) begin : g_left
        assign weight_in = weight_i[z];
        assign sum_in    = '0;
      end else begin : g_inner
        assign weight_in = weight_grid[z][k-1];
        assign sum_in    = sum_grid[z][k-1];
      end

      if (k < ACTIVATION_COUNT - 1) begin : g_w_right
        assign weight_grid[z][k] = weight_out;
      end else begin : g_w_last
        data_type weight_unused;
        assign weight_unused = weight_out;
      end

      systolic_pe u_pe (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .weight_update_i (weight_update_i),
        .weight_in       (weight_in),
        .act_in          (act_in),
        .sum_in          (sum_in),
        .weight_out      (weight_out),
        .act_out         (act_out),
        .sum_out         (sum_grid[z][k])
      );
    end
  end

  // Output register row: one extra stage after the rightmost PE column.
  data_type result_d [0:WEIGHT_COUNT-1];
  data_type result_q [0:WEIGHT_COUNT-1];

  always_comb begin
    for (int z = 0; z < WEIGHT_COUNT; z++) begin
      result_d[z] = sum_grid[z][ACTIVATION_COUNT-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int z = 0; z < WEIGHT_COUNT; z++) begin
        result_q[z] <= '0;
      end
    end else begin
      for (int z = 0; z < WEIGHT_COUNT; z++) begin
        result_q[z] <= result_d[z];
      end
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_systolic_array.sv
// -----------------------------------------------------------------------------
// tb_systolic_array
// Drives weight loads and skewed activation streams into systolic_array and
// checks every result element against a matrix-product model scheduled to the
// cycle it must appear on result_o.
// -----------------------------------------------------------------------------
module tb_systolic_array;
  import systolic_array_pkg::*;

  localparam int A = 16;  // ACTIVATION_COUNT, inner dimension
  localparam int W = 16;  // WEIGHT_COUNT, rows
  localparam int N = 16;  // columns of X streamed per run

  // ---------------------------------------------------------------- clock/reset
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_array_if #(.ACTIVATION_COUNT(A), .WEIGHT_COUNT(W)) bus ();

  systolic_array #(.ACTIVATION_COUNT(A), .WEIGHT_COUNT(W)) dut (
    .clk_i           (clk),
    .rst_i           (rst_n),
    .weight_update_i (bus.weight_update),
    .activation_i    (bus.activation),
    .weight_i        (bus.weight),
    .result_o        (bus.result)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [31:0] exp_q[$];
  int unsigned exp_cyc_q[$];
  int          exp_row_q[$];
  string       exp_tag_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Matrices of the current run: C = wm x xm.
  data_type wm [W][A];
  data_type xm [A][N];

  task automatic push_exp(input int unsigned c, input int row,
                          input logic [31:0] val, input string tag);
    exp_cyc_q.push_back(c);
    exp_row_q.push_back(row);
    exp_q.push_back(val);
    exp_tag_q.push_back(tag);
  endtask

  // Reference: plain matrix product with 32-bit wrap, each element scheduled
  // at c0 + j + z + A + 1, pushed in increasing cycle order.
  task automatic push_matrix_exp(input int unsigned c0, input string tag);
    data_type cm [W][N];
    for (int z = 0; z < W; z++) begin
      for (int j = 0; j < N; j++) begin
        data_type acc;
        acc = 0;
        for (int k = 0; k < A; k++) acc = acc + wm[z][k] * xm[k][j];
        cm[z][j] = acc;
      end
    end
    for (int t = 0; t < N + W - 1; t++) begin
      for (int z = 0; z < W; z++) begin
        int j;
        j = t - z;
        if (j >= 0 && j < N)
          push_exp(c0 + A + 1 + t, z, cm[z][j], tag);
      end
    end
  endtask

  // Monitor: pops every expectation that is due this cycle and compares.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      logic [31:0] e;
      int          r;
      string       tg;
      int unsigned ec;
      e  = exp_q.pop_front();
      r  = exp_row_q.pop_front();
      tg = exp_tag_q.pop_front();
      ec = exp_cyc_q.pop_front();
      n_cmp = n_cmp + 1;
      if (bus.result[r] !== e) begin
        n_err = n_err + 1;
        $display("FAIL %s row %0d cycle %0d: got %h, expected %h",
                 tg, r, ec, bus.result[r], e);
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic zero_inputs();
    bus.weight_update = 1'b0;
    for (int k = 0; k < A; k++) bus.activation[k] = '0;
    for (int z = 0; z < W; z++) bus.weight[z] = '0;
  endtask

  // Columns go in last-first so column 0 ends up in PE column 0.
  task automatic load_weights();
    for (int col = A - 1; col >= 0; col--) begin
      for (int z = 0; z < W; z++) bus.weight[z] = wm[z][col];
      bus.weight_update = 1'b1;
      @(posedge clk); #1;
    end
    zero_inputs();
  endtask

  // Called just after an edge; that cycle is cycle 0 of the skewed schedule.
  task automatic stream_x(input string tag);
    int unsigned c0;
    c0 = cyc;
    push_matrix_exp(c0, tag);
    for (int c = 0; c < N + A - 1; c++) begin
      for (int k = 0; k < A; k++) begin
        int j;
        j = c - k;
        bus.activation[k] = (j >= 0 && j < N) ? xm[k][j] : data_type'(0);
      end
      @(posedge clk); #1;
    end
    zero_inputs();
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 500) begin
      @(posedge clk);
      budget++;
    end
    #1;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d expectations outstanding, required 0", exp_q.size());
      $fatal(1, "scoreboard did not drain");
    end
  endtask

  function automatic data_type rand_small();
    return data_type'(int'($urandom_range(16382)) - 8191);
  endfunction

  task automatic run(input string tag);
    load_weights();
    stream_x(tag);
    drain();
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    zero_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;

    // Reset held with random inputs: all outputs stay zero.
    for (int i = 0; i < 10; i++) begin
      bus.weight_update = 1'($urandom_range(1));
      for (int k = 0; k < A; k++) bus.activation[k] = data_type'($urandom);
      for (int z = 0; z < W; z++) bus.weight[z] = data_type'($urandom);
      for (int z = 0; z < W; z++) push_exp(cyc, z, 32'h0, "reset_hold");
      @(posedge clk); #1;
    end
    zero_inputs();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      for (int z = 0; z < W; z++) push_exp(cyc, z, 32'h0, "post_reset");
      @(posedge clk); #1;
    end
    drain();

    // Identity weights, X[k][j] = k*16 + j.
    for (int z = 0; z < W; z++)
      for (int k = 0; k < A; k++) wm[z][k] = (z == k) ? 1 : 0;
    for (int k = 0; k < A; k++)
      for (int j = 0; j < N; j++) xm[k][j] = k * 16 + j;
    run("identity");

    // Reload with 2*I, same X: results must exactly double.
    for (int z = 0; z < W; z++)
      for (int k = 0; k < A; k++) wm[z][k] = (z == k) ? 2 : 0;
    run("reload_2i");

    // Random full matrices, two rounds.
    for (int rep = 0; rep < 2; rep++) begin
      for (int z = 0; z < W; z++)
        for (int k = 0; k < A; k++) wm[z][k] = rand_small();
      for (int k = 0; k < A; k++)
        for (int j = 0; j < N; j++) xm[k][j] = rand_small();
      run("random");
    end

    // Column order: W[z][k] = k+1, X all ones -> 136 everywhere.
    for (int z = 0; z < W; z++)
      for (int k = 0; k < A; k++) wm[z][k] = k + 1;
    for (int k = 0; k < A; k++)
      for (int j = 0; j < N; j++) xm[k][j] = 1;
    run("weight_order");

    // Wrap: 16 * (0x7FFFFFFF * 2) truncated -> -32.
    for (int z = 0; z < W; z++)
      for (int k = 0; k < A; k++) wm[z][k] = 32'h7FFF_FFFF;
    for (int k = 0; k < A; k++)
      for (int j = 0; j < N; j++) xm[k][j] = 2;
    run("wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
